// File: rtl/trace_pkg.sv
// Shared definitions for the control trace decoder: control-bus bit layout,
// fixed strobe patterns, instruction class and FSM state encodings.
package trace_pkg;

    localparam int unsigned BusW = 20;

    // Bus packing: {PCwrite, AddrSel, MemRead, MemWrite, IRload, R1Sel, MDRload,
    //               R1R2Load, ALU1, ALUOutWrite, RFWrite, RegIn, FlagWrite,
    //               IncCount, ALU2[2:0], ALUop[2:0]}
    localparam logic [BusW-1:0] MPcWrite     = 20'h80000;
    localparam logic [BusW-1:0] MAddrSel     = 20'h40000;
    localparam logic [BusW-1:0] MMemRead     = 20'h20000;
    localparam logic [BusW-1:0] MMemWrite    = 20'h10000;
    localparam logic [BusW-1:0] MIrLoad      = 20'h08000;
    localparam logic [BusW-1:0] MR1Sel       = 20'h04000;
    localparam logic [BusW-1:0] MMdrLoad     = 20'h02000;
    localparam logic [BusW-1:0] MR1R2Load    = 20'h01000;
    localparam logic [BusW-1:0] MAlu1        = 20'h00800;
    localparam logic [BusW-1:0] MAluOutWrite = 20'h00400;
    localparam logic [BusW-1:0] MRfWrite     = 20'h00200;
    localparam logic [BusW-1:0] MRegIn       = 20'h00100;
    localparam logic [BusW-1:0] MFlagWrite   = 20'h00080;
    localparam logic [BusW-1:0] MIncCount    = 20'h00040;

    localparam logic [BusW-1:0] AluBase = MAlu1 | MAluOutWrite | MFlagWrite | MIncCount;

    localparam logic [BusW-1:0] PatFetch  = MPcWrite | MAddrSel | MMemRead | MIrLoad | MIncCount
                                          | {14'b0, 3'b001, 3'b000};
    localparam logic [BusW-1:0] PatDecode = MR1R2Load | MIncCount;
    localparam logic [BusW-1:0] PatAdd    = AluBase | {14'b0, 3'b000, 3'b000};
    localparam logic [BusW-1:0] PatSub    = AluBase | {14'b0, 3'b000, 3'b001};
    localparam logic [BusW-1:0] PatNand   = AluBase | {14'b0, 3'b000, 3'b011};
    localparam logic [BusW-1:0] PatShift  = AluBase | {14'b0, 3'b100, 3'b100};
    localparam logic [BusW-1:0] PatOri3   = MR1Sel | MR1R2Load | MIncCount;
    localparam logic [BusW-1:0] PatOri4   = AluBase | {14'b0, 3'b011, 3'b010};
    localparam logic [BusW-1:0] PatOri5   = MR1Sel | MRfWrite | MIncCount;
    localparam logic [BusW-1:0] PatLoad3  = MMemRead | MMdrLoad | MIncCount;
    localparam logic [BusW-1:0] PatLoad4  = MAluOutWrite | MRfWrite | MRegIn | MIncCount;
    localparam logic [BusW-1:0] PatStore  = MMemWrite | MIncCount;
    // PCwrite is left clear here; the matcher masks it out for the branch cycle.
    localparam logic [BusW-1:0] PatBranch = MIncCount | {14'b0, 3'b010, 3'b000};
    localparam logic [BusW-1:0] PatNop    = MIncCount;
    localparam logic [BusW-1:0] PatWb     = MRfWrite | MIncCount;

    typedef enum logic [3:0] {
        ClsAdd    = 4'd0,
        ClsSub    = 4'd1,
        ClsNand   = 4'd2,
        ClsShift  = 4'd3,
        ClsOri    = 4'd4,
        ClsLoad   = 4'd5,
        ClsStore  = 4'd6,
        ClsBranch = 4'd7,
        ClsNop    = 4'd8,
        ClsStop   = 4'd9
    } instr_class_e;

    typedef enum logic [2:0] {
        StIdle,
        StDec,
        StExec3,
        StWbAsn,
        StOri4,
        StOri5,
        StLd4,
        StHalt
    } trace_state_e;

    typedef struct packed {
        logic fetch;
        logic decode;
        logic add;
        logic sub;
        logic nand_op;
        logic shift;
        logic ori3;
        logic ori4;
        logic ori5;
        logic load3;
        logic load4;
        logic store;
        logic branch;
        logic nop;
        logic zero;
        logic wb;
    } pat_hits_t;

endpackage

// File: rtl/control_trace_decoder_if.sv
// Observed control-strobe bundle from the multi-cycle control FSM.
interface control_trace_decoder_if;
    logic       PCwrite;
    logic       AddrSel;
    logic       MemRead;
    logic       MemWrite;
    logic       IRload;
    logic       R1Sel;
    logic       MDRload;
    logic       R1R2Load;
    logic       ALU1;
    logic       ALUOutWrite;
    logic       RFWrite;
    logic       RegIn;
    logic       FlagWrite;
    logic       IncCount;
    logic [2:0] ALU2;
    logic [2:0] ALUop;

    modport master (
        output PCwrite, AddrSel, MemRead, MemWrite, IRload, R1Sel, MDRload, R1R2Load,
               ALU1, ALUOutWrite, RFWrite, RegIn, FlagWrite, IncCount, ALU2, ALUop
    );

    modport slave (
        input  PCwrite, AddrSel, MemRead, MemWrite, IRload, R1Sel, MDRload, R1R2Load,
               ALU1, ALUOutWrite, RFWrite, RegIn, FlagWrite, IncCount, ALU2, ALUop
    );
endinterface

// File: rtl/ctrl_pattern_match.sv
// Combinational classifier: exact-match the packed control word against every
// legal strobe pattern and report one-hot hits.
module ctrl_pattern_match
    import trace_pkg::*;
(
    input  logic [BusW-1:0] i_bus,
    output pat_hits_t       o_hits
);

    always_comb begin
        o_hits         = '0;
        o_hits.fetch   = (i_bus == PatFetch);
        o_hits.decode  = (i_bus == PatDecode);
        o_hits.add     = (i_bus == PatAdd);
        o_hits.sub     = (i_bus == PatSub);
        o_hits.nand_op = (i_bus == PatNand);
        o_hits.shift   = (i_bus == PatShift);
        o_hits.ori3    = (i_bus == PatOri3);
        o_hits.ori4    = (i_bus == PatOri4);
        o_hits.ori5    = (i_bus == PatOri5);
        o_hits.load3   = (i_bus == PatLoad3);
        o_hits.load4   = (i_bus == PatLoad4);
        o_hits.store   = (i_bus == PatStore);
        o_hits.branch  = ((i_bus & ~MPcWrite) == PatBranch);
        o_hits.nop     = (i_bus == PatNop);
        o_hits.zero    = (i_bus == '0);
        o_hits.wb      = (i_bus == PatWb);
    end

endmodule

// File: rtl/control_trace_decoder.sv
// Passive control-bus monitor: rebuilds the retired instruction stream from
// the control FSM strobes and flags sequences the FSM cannot produce.
module control_trace_decoder
    import trace_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic                          clock,
    input  logic                          reset,
    control_trace_decoder_if.slave        bus,
    output logic                          retire,
    output logic [3:0]                    retire_class,
    output logic [2:0]                    retire_cycles,
    output logic                          branch_taken,
    output logic [CNT_W-1:0]              instr_count,
    output logic                          seq_error,
    output logic                          halted
);

    logic [BusW-1:0] w_bus;
    pat_hits_t       w_hits;

    assign w_bus = {bus.PCwrite, bus.AddrSel, bus.MemRead, bus.MemWrite, bus.IRload,
                    bus.R1Sel, bus.MDRload, bus.R1R2Load, bus.ALU1, bus.ALUOutWrite,
                    bus.RFWrite, bus.RegIn, bus.FlagWrite, bus.IncCount, bus.ALU2,
                    bus.ALUop};

    ctrl_pattern_match u_match (
        .i_bus  (w_bus),
        .o_hits (w_hits)
    );

    trace_state_e     r_state, w_state_d;
    instr_class_e     r_held_cls, w_held_cls_d;
    logic             r_retire, w_retire_d;
    instr_class_e     r_class, w_class_d;
    logic [2:0]       r_cycles, w_cycles_d;
    logic             r_branch, w_branch_d;
    logic [CNT_W-1:0] r_count;
    logic             r_err, w_err_set;
    logic             r_halted, w_halt_set;
    logic             w_bad;

    always_comb begin
        w_state_d    = r_state;
        w_held_cls_d = r_held_cls;
        w_retire_d   = 1'b0;
        w_class_d    = ClsAdd;
        w_cycles_d   = 3'd0;
        w_branch_d   = 1'b0;
        w_err_set    = 1'b0;
        w_halt_set   = 1'b0;
        w_bad        = 1'b0;

        unique case (r_state)
            StIdle: begin
                if (w_hits.fetch) begin
                    w_state_d = StDec;
                end else if (!w_hits.zero) begin
                    w_err_set = 1'b1;
                end
            end
            StDec: begin
                if (w_hits.decode) w_state_d = StExec3;
                else               w_bad     = 1'b1;
            end
            StExec3: begin
                if (w_hits.add || w_hits.sub || w_hits.nand_op || w_hits.shift) begin
                    w_state_d    = StWbAsn;
                    w_held_cls_d = w_hits.add     ? ClsAdd  :
                                   w_hits.sub     ? ClsSub  :
                                   w_hits.nand_op ? ClsNand : ClsShift;
                end else if (w_hits.ori3) begin
                    w_state_d = StOri4;
                end else if (w_hits.load3) begin
                    w_state_d = StLd4;
                end else if (w_hits.store || w_hits.branch || w_hits.nop || w_hits.zero) begin
                    w_retire_d = 1'b1;
                    w_cycles_d = 3'd3;
                    w_state_d  = StIdle;
                    if (w_hits.store) begin
                        w_class_d = ClsStore;
                    end else if (w_hits.branch) begin
                        w_class_d  = ClsBranch;
                        w_branch_d = bus.PCwrite;
                    end else if (w_hits.nop) begin
                        w_class_d = ClsNop;
                    end else begin
                        w_class_d  = ClsStop;
                        w_state_d  = StHalt;
                        w_halt_set = 1'b1;
                    end
                end else begin
                    w_bad = 1'b1;
                end
            end
            StWbAsn: begin
                if (w_hits.wb) begin
                    w_retire_d = 1'b1;
                    w_class_d  = r_held_cls;
                    w_cycles_d = 3'd4;
                    w_state_d  = StIdle;
                end else begin
                    w_bad = 1'b1;
                end
            end
            StOri4: begin
                if (w_hits.ori4) w_state_d = StOri5;
                else             w_bad     = 1'b1;
            end
            StOri5: begin
                if (w_hits.ori5) begin
                    w_retire_d = 1'b1;
                    w_class_d  = ClsOri;
                    w_cycles_d = 3'd5;
                    w_state_d  = StIdle;
                end else begin
                    w_bad = 1'b1;
                end
            end
            StLd4: begin
                if (w_hits.load4) begin
                    w_retire_d = 1'b1;
                    w_class_d  = ClsLoad;
                    w_cycles_d = 3'd4;
                    w_state_d  = StIdle;
                end else begin
                    w_bad = 1'b1;
                end
            end
            StHalt: begin
                w_state_d = StHalt;
            end
            default: w_state_d = StIdle;
        endcase

        // A stray FETCH mid-instruction is taken as the start of a new one.
        if (w_bad) begin
            w_err_set = 1'b1;
            w_state_d = w_hits.fetch ? StDec : StIdle;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= StIdle;
            r_held_cls <= ClsAdd;
            r_retire   <= 1'b0;
            r_class    <= ClsAdd;
            r_cycles   <= 3'd0;
            r_branch   <= 1'b0;
            r_count    <= '0;
            r_err      <= 1'b0;
            r_halted   <= 1'b0;
        end else begin
            r_state    <= w_state_d;
            r_held_cls <= w_held_cls_d;
            r_retire   <= w_retire_d;
            r_class    <= w_class_d;
            r_cycles   <= w_cycles_d;
            r_branch   <= w_branch_d;
            r_err      <= r_err | w_err_set;
            r_halted   <= r_halted | w_halt_set;
            if (w_retire_d && (r_count != '1)) begin
                r_count <= r_count + 1'b1;
            end
        end
    end

    assign retire        = r_retire;
    assign retire_class  = r_class;
    assign retire_cycles = r_cycles;
    assign branch_taken  = r_branch;
    assign instr_count   = r_count;
    assign seq_error     = r_err;
    assign halted        = r_halted;

endmodule

// File: tb/tb_control_trace_decoder.sv
// Randomized self-checking bench for control_trace_decoder with an
// instruction-level reference model.
module tb_control_trace_decoder;

    localparam int unsigned CntW   = 8;
    localparam int          CntMax = 255;

    localparam logic [19:0] PC  = 20'h80000;
    localparam logic [19:0] AS  = 20'h40000;
    localparam logic [19:0] MR  = 20'h20000;
    localparam logic [19:0] MW  = 20'h10000;
    localparam logic [19:0] IR  = 20'h08000;
    localparam logic [19:0] R1S = 20'h04000;
    localparam logic [19:0] MDR = 20'h02000;
    localparam logic [19:0] R12 = 20'h01000;
    localparam logic [19:0] A1  = 20'h00800;
    localparam logic [19:0] AOW = 20'h00400;
    localparam logic [19:0] RFW = 20'h00200;
    localparam logic [19:0] RIN = 20'h00100;
    localparam logic [19:0] FW  = 20'h00080;
    localparam logic [19:0] INC = 20'h00040;

    logic clock = 1'b0;
    logic reset;

    control_trace_decoder_if bus_if ();

    logic            retire;
    logic [3:0]      retire_class;
    logic [2:0]      retire_cycles;
    logic            branch_taken;
    logic [CntW-1:0] instr_count;
    logic            seq_error;
    logic            halted;

    control_trace_decoder #(.CNT_W(CntW)) dut (
        .clock         (clock),
        .reset         (reset),
        .bus           (bus_if.slave),
        .retire        (retire),
        .retire_class  (retire_class),
        .retire_cycles (retire_cycles),
        .branch_taken  (branch_taken),
        .instr_count   (instr_count),
        .seq_error     (seq_error),
        .halted        (halted)
    );

    always #5 clock = ~clock;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          exp_count;
    logic        exp_err;
    logic        exp_halt;
    logic [19:0] seq [5];
    int          seq_n;

    function automatic logic [19:0] a2(input logic [2:0] v);
        return {14'b0, v, 3'b000};
    endfunction

    function automatic logic [19:0] op(input logic [2:0] v);
        return {17'b0, v};
    endfunction

    function automatic logic [19:0] fetch_pat();
        return PC | AS | MR | IR | INC | a2(3'b001);
    endfunction

    task automatic drive(input logic [19:0] v);
        {bus_if.PCwrite, bus_if.AddrSel, bus_if.MemRead, bus_if.MemWrite, bus_if.IRload,
         bus_if.R1Sel, bus_if.MDRload, bus_if.R1R2Load, bus_if.ALU1, bus_if.ALUOutWrite,
         bus_if.RFWrite, bus_if.RegIn, bus_if.FlagWrite, bus_if.IncCount, bus_if.ALU2,
         bus_if.ALUop} = v;
    endtask

    // Apply one control cycle; outputs are sampled 1 time unit after the edge.
    task automatic step(input logic [19:0] v);
        drive(v);
        @(posedge clock);
        #1;
    endtask

    // Expand an instruction class into its control-cycle sequence.
    task automatic build(input int cls, input bit br);
        logic [2:0] o;
        seq[0] = fetch_pat();
        seq[1] = R12 | INC;
        seq_n  = 3;
        case (cls)
            0, 1, 2: begin
                o = (cls == 0) ? 3'd0 : (cls == 1) ? 3'd1 : 3'd3;
                seq[2] = A1 | AOW | FW | INC | a2(3'd0) | op(o);
                seq[3] = RFW | INC;
                seq_n  = 4;
            end
            3: begin
                seq[2] = A1 | AOW | FW | INC | a2(3'd4) | op(3'd4);
                seq[3] = RFW | INC;
                seq_n  = 4;
            end
            4: begin
                seq[2] = R1S | R12 | INC;
                seq[3] = A1 | AOW | FW | INC | a2(3'd3) | op(3'd2);
                seq[4] = R1S | RFW | INC;
                seq_n  = 5;
            end
            5: begin
                seq[2] = MR | MDR | INC;
                seq[3] = AOW | RFW | RIN | INC;
                seq_n  = 4;
            end
            6:       seq[2] = MW | INC;
            7:       seq[2] = a2(3'd2) | INC | (br ? PC : 20'h0);
            8:       seq[2] = INC;
            default: seq[2] = 20'h0;
        endcase
    endtask

    task automatic run_instr(input int cls, input bit br, input bit chk);
        logic [3:0] ecls;
        logic [2:0] ecyc;
        logic       ebr;
        build(cls, br);
        for (int i = 0; i < seq_n; i++) begin
            step(seq[i]);
            if (chk && (i < seq_n - 1)) begin
                n_tests++;
                if (retire !== 1'b0) begin
                    n_fail++;
                    $display("FAIL early_retire cls=%0d cyc=%0d: got %b want 0", cls, i, retire);
                end
            end
        end
        if (exp_count < CntMax) exp_count++;
        if (cls == 9) exp_halt = 1'b1;
        ecls = 4'(cls);
        ecyc = 3'(seq_n);
        ebr  = (cls == 7) ? br : 1'b0;
        if (chk) begin
            n_tests++;
            if (retire !== 1'b1) begin
                n_fail++;
                $display("FAIL retire cls=%0d: got %b want 1", cls, retire);
            end
            n_tests++;
            if (retire_class !== ecls) begin
                n_fail++;
                $display("FAIL retire_class: got %0d want %0d", retire_class, ecls);
            end
            n_tests++;
            if (retire_cycles !== ecyc) begin
                n_fail++;
                $display("FAIL retire_cycles cls=%0d: got %0d want %0d", cls, retire_cycles, ecyc);
            end
            n_tests++;
            if (branch_taken !== ebr) begin
                n_fail++;
                $display("FAIL branch_taken cls=%0d: got %b want %b", cls, branch_taken, ebr);
            end
            n_tests++;
            if (instr_count !== CntW'(exp_count)) begin
                n_fail++;
                $display("FAIL instr_count: got %0d want %0d", instr_count, exp_count);
            end
            n_tests++;
            if (seq_error !== exp_err || halted !== exp_halt) begin
                n_fail++;
                $display("FAIL flags: got err=%b halt=%b want err=%b halt=%b",
                         seq_error, halted, exp_err, exp_halt);
            end
        end
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        step(20'h0);
        step(20'h0);
        reset = 1'b0;
        exp_count = 0;
        exp_err   = 1'b0;
        exp_halt  = 1'b0;
    endtask

    task automatic check_zero_outputs(input string tag);
        n_tests++;
        if ({retire, retire_class, retire_cycles, branch_taken, instr_count, seq_error,
             halted} !== '0) begin
            n_fail++;
            $display("FAIL %s: got ret=%b cls=%0d cyc=%0d br=%b cnt=%0d err=%b halt=%b want all 0",
                     tag, retire, retire_class, retire_cycles, branch_taken, instr_count,
                     seq_error, halted);
        end
    endtask

    task automatic test_reset();
        apply_reset();
        check_zero_outputs("reset_state");
        step(20'h0);
        check_zero_outputs("idle_zero_bus");
    endtask

    task automatic test_add();
        run_instr(0, 1'b0, 1'b1);
    endtask

    task automatic test_ori_load();
        run_instr(4, 1'b0, 1'b1);
        run_instr(5, 1'b0, 1'b1);
    endtask

    task automatic test_branch();
        run_instr(7, 1'b1, 1'b1);
        run_instr(7, 1'b0, 1'b1);
        run_instr(7, 1'b1, 1'b1);
    endtask

    task automatic test_random();
        for (int k = 0; k < 40; k++) begin
            run_instr(int'($urandom_range(0, 8)), 1'($urandom_range(0, 1)), 1'b1);
            if ($urandom_range(0, 3) == 0) step(20'h0);
        end
    endtask

    task automatic test_error();
        apply_reset();
        step(INC);
        exp_err = 1'b1;
        n_tests++;
        if (seq_error !== 1'b1 || retire !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_junk: got err=%b ret=%b want err=1 ret=0", seq_error, retire);
        end

        apply_reset();
        step(fetch_pat());
        step(R12 | INC);
        step(MW | RFW);
        exp_err = 1'b1;
        n_tests++;
        if (seq_error !== 1'b1 || retire !== 1'b0) begin
            n_fail++;
            $display("FAIL bad_exec3: got err=%b ret=%b want err=1 ret=0", seq_error, retire);
        end
        run_instr(8, 1'b0, 1'b1);

        apply_reset();
        step(fetch_pat());
        step(R12 | INC);
        step(fetch_pat());
        exp_err = 1'b1;
        n_tests++;
        if (seq_error !== 1'b1 || retire !== 1'b0) begin
            n_fail++;
            $display("FAIL stray_fetch: got err=%b ret=%b want err=1 ret=0", seq_error, retire);
        end
        step(R12 | INC);
        step(INC);
        if (exp_count < CntMax) exp_count++;
        n_tests++;
        if (retire !== 1'b1 || retire_class !== 4'd8 || retire_cycles !== 3'd3 ||
            instr_count !== CntW'(exp_count)) begin
            n_fail++;
            $display("FAIL resync_nop: got ret=%b cls=%0d cyc=%0d cnt=%0d want 1/8/3/%0d",
                     retire, retire_class, retire_cycles, instr_count, exp_count);
        end
    endtask

    task automatic test_saturation();
        apply_reset();
        for (int k = 0; k < CntMax - 1; k++) run_instr(8, 1'b0, 1'b0);
        n_tests++;
        if (instr_count !== CntW'(exp_count)) begin
            n_fail++;
            $display("FAIL preload_count: got %0d want %0d", instr_count, exp_count);
        end
        for (int k = 0; k < 3; k++) run_instr(8, 1'b0, 1'b1);
    endtask

    task automatic test_reset_mid();
        build(4, 1'b0);
        step(seq[0]);
        step(seq[1]);
        step(seq[2]);
        reset = 1'b1;
        step(seq[3]);
        check_zero_outputs("reset_in_ori4");
        reset = 1'b0;
        exp_count = 0;
        exp_err   = 1'b0;
        exp_halt  = 1'b0;
        run_instr(0, 1'b0, 1'b1);
    endtask

    task automatic test_stop();
        int cnt_at_halt;
        run_instr(9, 1'b0, 1'b1);
        cnt_at_halt = exp_count;
        build(0, 1'b0);
        for (int i = 0; i < seq_n; i++) begin
            step(seq[i]);
            n_tests++;
            if (retire !== 1'b0 || instr_count !== CntW'(cnt_at_halt) ||
                seq_error !== exp_err || halted !== 1'b1) begin
                n_fail++;
                $display("FAIL halted_ignore cyc=%0d: got ret=%b cnt=%0d err=%b halt=%b want 0/%0d/%b/1",
                         i, retire, instr_count, seq_error, halted, cnt_at_halt, exp_err);
            end
        end
        step(20'hFFFFF);
        n_tests++;
        if (seq_error !== exp_err || halted !== 1'b1 || retire !== 1'b0) begin
            n_fail++;
            $display("FAIL halted_junk: got err=%b halt=%b ret=%b want %b/1/0",
                     seq_error, halted, retire, exp_err);
        end
    endtask

    initial begin
        reset = 1'b1;
        drive(20'h0);
        exp_count = 0;
        exp_err   = 1'b0;
        exp_halt  = 1'b0;
        test_reset();
        test_add();
        test_ori_load();
        test_branch();
        test_random();
        test_error();
        test_saturation();
        test_reset_mid();
        test_stop();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/control_trace_decoder.md
# control_trace_decoder

Passive monitor on the multi-cycle processor's control bus. It watches the per-cycle control strobes driven by the control FSM and rebuilds the instruction stream from them. It reports each retired instruction's class, cycle count and branch outcome, keeps a saturating retired-instruction count, and flags any control sequence the FSM could not legally produce. It sits beside the datapath, drives nothing back into the processor, and feeds debug and performance logic.

## Interface
- `CNT_W`, default 16: width of `instr_count`.
- `clock` in 1: system clock.
- `reset` in 1: synchronous, active-high; one clock; reset is synchronous and active-high.
- `PCwrite, AddrSel, MemRead, MemWrite, IRload, R1Sel, MDRload, R1R2Load, ALU1, ALUOutWrite, RFWrite, RegIn, FlagWrite, IncCount` in 1 each: observed control strobes.
- `ALU2` in 3: observed ALU operand-2 select.
- `ALUop` in 3: observed ALU operation.
- `retire` out 1: one-cycle pulse per completed instruction.
- `retire_class` out 4: class of the retired instruction, valid with `retire`.
- `retire_cycles` out 3: cycles from fetch to last control cycle inclusive, valid with `retire`.
- `branch_taken` out 1: PCwrite value in the branch cycle, valid with `retire` when class is BRANCH, else 0.
- `instr_count` out CNT_W: retired instructions; saturates at all-ones.
- `seq_error` out 1: sticky illegal-sequence flag.
- `halted` out 1: stop recognised; sticky until reset.

## Operation
- Pattern matching is an exact match on all 20 control bits; the only exception is PCwrite in the branch cycle. Unlisted bits must be 0.
- Fixed patterns:
  - FETCH: PCwrite, AddrSel, MemRead, IRload, IncCount = 1, ALU2 = 001.
  - DECODE: R1R2Load, IncCount = 1.
- States: IDLE, DEC, EXEC3, WB_ASN, ORI4, ORI5, LD4, HALT.
- IDLE:
  - FETCH pattern → DEC.
  - All-zero bus → stay, no error (this is the reset state).
  - Any other pattern → stay and set `seq_error`.
- DEC: DECODE → EXEC3; otherwise error.
- EXEC3 classifies the cycle-3 pattern:
  - ALU1, ALUOutWrite, FlagWrite, IncCount, ALU2 = 000, with ALUop 000/001/011 → ADD/SUB/NAND; go to WB_ASN.
  - Same as above but ALU2 = 100, ALUop = 100 → SHIFT; go to WB_ASN.
  - R1Sel, R1R2Load, IncCount → ORI; go to ORI4.
  - MemRead, MDRload, IncCount → LOAD; go to LD4.
  - MemWrite, IncCount → retire STORE, 3 cycles.
  - ALU2 = 010, IncCount, PCwrite = either → retire BRANCH, 3 cycles, with `branch_taken` = PCwrite.
  - IncCount only → retire NOP, 3 cycles.
  - All-zero → retire STOP, 3 cycles, then HALT.
- Later states:
  - WB_ASN: RFWrite, IncCount → retire the held class, 4 cycles.
  - ORI4: ALU1, ALUOutWrite, FlagWrite, IncCount, ALU2 = 011, ALUop = 010 → ORI5.
  - ORI5: R1Sel, RFWrite, IncCount → retire ORI, 5 cycles.
  - LD4: ALUOutWrite, RFWrite, RegIn, IncCount → retire LOAD, 4 cycles.
- After each retirement the state returns to IDLE, where the next FETCH is expected.
- Errors: if any state other than IDLE or HALT sees an unexpected pattern, `seq_error` is set and no retire occurs.
  - If the unexpected pattern is FETCH, it is treated as a new instruction and the state goes to DEC.
  - Otherwise the state goes to IDLE to resync.
- HALT ignores all inputs; only `reset` leaves it. `instr_count` is frozen in HALT.
- Class encoding (shared): ADD = 0, SUB = 1, NAND = 2, SHIFT = 3, ORI = 4, LOAD = 5, STORE = 6, BRANCH = 7, NOP = 8, STOP = 9.

## Timing
- All outputs are registered.
- `retire` and its qualifiers assert in the cycle after the instruction's final control cycle; for back-to-back instructions this is the next FETCH cycle.
- `instr_count` updates in the same cycle as `retire`.
- `halted` and `seq_error` assert in the cycle after the triggering pattern.
- Reset values: state = IDLE; `retire`, `retire_class`, `retire_cycles`, `branch_taken`, `seq_error`, `halted` = 0; `instr_count` = 0.
- Reset asserted mid-instruction discards the partial instruction with no retire and no error.
- `instr_count` saturates and never wraps.
- A retire and a `seq_error` set can never occur in the same cycle.

## Structure
- Shared package `trace_pkg`: class encoding constants, state encoding, and the FETCH/DECODE pattern constants.
- One natural sub-module, `ctrl_pattern_match`: a combinational classifier that packs the 20 bits and emits one-hot pattern hits.
- The FSM and output registers live in the top module.

## Test plan
- ADD sequence FETCH, DECODE, ADD pattern, RFWrite → `retire` = 1 with class 0 and cycles 4 on the following cycle; `instr_count` = 1.
- ORI then LOAD back-to-back → two retires: class 4 / 5 cycles, then class 5 / 4 cycles; `instr_count` = 2; `seq_error` = 0.
- Three branches with PCwrite = 1, 0, 1 → three retires of class 7 / 3 cycles with `branch_taken` = 1, 0, 1.
- STOP (IncCount = 0 in cycle 3) → retire class 9, `halted` = 1. A subsequent ADD sequence produces no retire and no change to `instr_count` or `seq_error`.
- After DECODE, inject a MemWrite + RFWrite pattern → `seq_error` = 1, no retire. A following full NOP sequence retires class 8 / 3 cycles.
- Preload `instr_count` to 0xFFFE via 65534 NOPs, then run 3 more NOPs → count reads 0xFFFF and holds. Reset asserted in ORI4 → all outputs 0 next cycle.
